// File: rtl/simple_bus_pkg.sv
// Shared types for the simple_bus requester: bus field widths, command
// mode encoding, the queued command record and the requester FSM states.
package simple_bus_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_RD  = 2'd0,
    MODE_WR  = 2'd1,
    MODE_RMW = 2'd2,
    MODE_NOP = 2'd3
  } sb_mode_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    sb_mode_e          mode;
  } sb_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } sb_state_e;

endpackage

// File: rtl/sb_cmd_fifo.sv
// Command FIFO for the simple_bus requester. DEPTH must be a power of two
// so the read/write pointers wrap naturally. Push is refused when full and
// pop is refused when empty; a simultaneous push and pop leaves the
// occupancy unchanged. No bypass: a pushed entry is visible one cycle later.
module sb_cmd_fifo
  import simple_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push_i,
  input  sb_cmd_t push_data_i,
  input  logic    pop_i,
  output sb_cmd_t pop_data_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  sb_cmd_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/simple_bus_requester.sv
// Bus-master front end for simple_bus. Commands are queued in sb_cmd_fifo;
// the FSM pops one in IDLE, raises req, waits for gnt, pulses start for one
// cycle, then waits for ready and pulses done.
// Optional feature macro: SIMPLE_BUS_REQ_TIMEOUT_EN -- when defined, a
// TIMEOUT_CYC watchdog aborts a stalled REQ/WAIT with a one-cycle err pulse
// and drops the command; when undefined err is constant 0.
module simple_bus_requester
  import simple_bus_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [MODE_W-1:0] cmd_mode,
  output logic              req,
  input  logic              gnt,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic [MODE_W-1:0] mode,
  output logic              start,
  input  logic              ready,
  output logic              done,
  output logic              busy,
  output logic              err
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("simple_bus_requester: DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("simple_bus_requester: TIMEOUT_CYC must be >= 2");
  end

  sb_state_e state_q, state_d;
  sb_cmd_t   cmd_q, cmd_d;
  sb_cmd_t   fifo_in;
  sb_cmd_t   fifo_head;
  logic      req_q, req_d;
  logic      start_q, start_d;
  logic      done_q, done_d;
  logic      err_q, err_d;
  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_pop;
  logic      to_hit;

  assign fifo_in = '{addr: cmd_addr, data: cmd_data, mode: sb_mode_e'(cmd_mode)};

  sb_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (cmd_valid),
    .push_data_i (fifo_in),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

`ifdef SIMPLE_BUS_REQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  // Watchdog: restart on every entry into REQ or WAIT, count while there.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_d == ST_REQ  && state_q != ST_REQ) ||
        (state_d == ST_WAIT && state_q != ST_WAIT)) begin
      to_cnt_d = '0;
    end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  // Next-state and registered-output logic; start/done/err are pulses.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    req_d    = req_q;
    start_d  = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_head;
          req_d    = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (gnt) begin
          start_d = 1'b1;
          state_d = ST_START;
        end else if (to_hit) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ready) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (to_hit) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and bus-side output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      req_q   <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      req_q   <= req_d;
      start_q <= start_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = !fifo_full;
  assign req       = req_q;
  assign addr      = cmd_q.addr;
  assign data      = cmd_q.data;
  assign mode      = cmd_q.mode;
  assign start     = start_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_simple_bus_requester.sv
// Directed self-checking bench for simple_bus_requester (DEPTH=4,
// TIMEOUT_CYC=16). Inputs are driven and outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_simple_bus_requester;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_addr = 8'h00;
  logic [7:0] cmd_data = 8'h00;
  logic [1:0] cmd_mode = 2'd0;
  logic       req;
  logic       gnt = 1'b0;
  logic [7:0] addr;
  logic [7:0] data;
  logic [1:0] mode;
  logic       start;
  logic       ready = 1'b0;
  logic       done;
  logic       busy;
  logic       err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  int err_cnt = 0;
  logic [17:0] done_log[$];

  simple_bus_requester #(.DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mode(cmd_mode),
    .req(req), .gnt(gnt), .addr(addr), .data(data), .mode(mode),
    .start(start), .ready(ready), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Pulse monitor: records completions (with the command on the bus) and strobes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        done_cnt++;
        done_log.push_back({addr, data, mode});
      end
      if (start) start_cnt++;
      if (err) err_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one command and hold it until accepted (bounded).
  task automatic push(input logic [7:0] a, input logic [7:0] d, input logic [1:0] m);
    int cyc = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_mode = m;
    while (!cmd_ready && cyc < 50) begin @(negedge clk); cyc++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (cyc >= 50) begin errors++; $display("FAIL push_accept: addr=%h not accepted within %0d cycles", a, cyc); end
  endtask

  // Reactive slave: grant whenever req is seen, ready one cycle after start.
  task automatic serve(input int n, input int budget);
    int   served = 0;
    int   cyc = 0;
    logic rdy_nxt = 1'b0;
    while (served < n && cyc < budget) begin
      @(negedge clk); cyc++;
      if (done) served++;
      gnt = req; ready = rdy_nxt; rdy_nxt = start;
    end
    gnt = 1'b0; ready = 1'b0;
    checks++;
    if (served != n) begin errors++; $display("FAIL serve_done: completed %0d expected %0d", served, n); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++; if ({req, start, done, err, busy} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: req/start/done/err/busy=%b expected 00000", {req, start, done, err, busy}); end
    checks++; if ({addr, data, mode} !== 18'h0) begin errors++; $display("FAIL reset_bus: addr/data/mode=%h expected 0", {addr, data, mode}); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_simple();
    int d0 = done_cnt;
    int s0 = start_cnt;
    push(8'h12, 8'hA5, 2'd1);
    checks++; if (req !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL simple_push_edge: req=%b busy=%b expected 0/1", req, busy); end
    tick(); // T
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL simple_req_T: req=%b expected 1", req); end
    checks++; if ({addr, data, mode} !== {8'h12, 8'hA5, 2'd1}) begin errors++; $display("FAIL simple_bus_T: got %h/%h/%0d expected 12/a5/1", addr, data, mode); end
    tick(); // T+1
    checks++; if (start !== 1'b0 || req !== 1'b1) begin errors++; $display("FAIL simple_T1: start=%b req=%b expected 0/1", start, req); end
    gnt = 1'b1;
    tick(); // T+2
    checks++; if (start !== 1'b1) begin errors++; $display("FAIL simple_start_T2: start=%b expected 1", start); end
    gnt = 1'b0;
    tick(); // T+3
    checks++; if (start !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL simple_T3: start=%b done=%b expected 0/0", start, done); end
    checks++; if ({addr, data, mode} !== {8'h12, 8'hA5, 2'd1}) begin errors++; $display("FAIL simple_bus_T3: got %h/%h/%0d expected 12/a5/1", addr, data, mode); end
    ready = 1'b1;
    tick(); // T+4
    ready = 1'b0;
    checks++; if (done !== 1'b1 || req !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL simple_done_T4: done=%b req=%b err=%b expected 1/0/0", done, req, err); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL simple_after: done=%b busy=%b expected 0/0", done, busy); end
    checks++; if (done_cnt - d0 != 1 || start_cnt - s0 != 1) begin errors++; $display("FAIL simple_counts: done=%0d start=%0d expected 1/1", done_cnt - d0, start_cnt - s0); end
    checks++; if (done_log[$] !== {8'h12, 8'hA5, 2'd1}) begin errors++; $display("FAIL simple_log: got %h expected %h", done_log[$], {8'h12, 8'hA5, 2'd1}); end
  endtask

  task automatic test_backpressure();
    int base = done_log.size();
    int s0 = start_cnt;
    logic [17:0] exp;
    gnt = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i), 8'h50 + 8'(i), 2'(i));
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_3: cmd_ready=%b expected 1", cmd_ready); end
    push(8'h24, 8'h54, 2'd0);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_full: cmd_ready=%b expected 0", cmd_ready); end
    checks++; if (req !== 1'b1 || start !== 1'b0 || addr !== 8'h20) begin errors++; $display("FAIL bp_head_req: req=%b start=%b addr=%h expected 1/0/20", req, start, addr); end
    cmd_valid = 1'b1; cmd_addr = 8'hEE; cmd_data = 8'hEE; cmd_mode = 2'd3;
    tick(); tick();
    cmd_valid = 1'b0;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_still_full: cmd_ready=%b expected 0", cmd_ready); end
    serve(5, 200);
    tick();
    checks++; if (done_log.size() - base != 5) begin errors++; $display("FAIL bp_done_count: got %0d expected 5", done_log.size() - base); end
    for (int i = 0; i < 5 && base + i < done_log.size(); i++) begin
      exp = {8'h20 + 8'(i), 8'h50 + 8'(i), 2'(i)};
      checks++; if (done_log[base + i] !== exp) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", i, done_log[base + i], exp); end
    end
    checks++; if (start_cnt - s0 != 5) begin errors++; $display("FAIL bp_starts: got %0d expected 5", start_cnt - s0); end
  endtask

  task automatic test_push_pop();
    int base = done_log.size();
    logic [17:0] exp;
    gnt = 1'b0;
    for (int i = 0; i < 3; i++) push(8'h40 + 8'(i), 8'h70 + 8'(i), 2'(i));
    serve(1, 50);
    cmd_valid = 1'b1; cmd_addr = 8'h43; cmd_data = 8'h73; cmd_mode = 2'd3;
    tick();
    cmd_valid = 1'b0;
    checks++; if (req !== 1'b1 || addr !== 8'h41) begin errors++; $display("FAIL pp_next_head: req=%b addr=%h expected 1/41", req, addr); end
    push(8'h44, 8'h74, 2'd0);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL pp_count3: cmd_ready=%b expected 1", cmd_ready); end
    push(8'h45, 8'h75, 2'd1);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL pp_count4: cmd_ready=%b expected 0", cmd_ready); end
    serve(5, 200);
    tick();
    checks++; if (done_log.size() - base != 6) begin errors++; $display("FAIL pp_done_count: got %0d expected 6", done_log.size() - base); end
    for (int i = 0; i < 6 && base + i < done_log.size(); i++) begin
      exp = {8'h40 + 8'(i), 8'h70 + 8'(i), 2'(i)};
      checks++; if (done_log[base + i] !== exp) begin errors++; $display("FAIL pp_order[%0d]: got %h expected %h", i, done_log[base + i], exp); end
    end
  endtask

  task automatic test_stray();
    int d0 = done_cnt;
    int s0 = start_cnt;
    ready = 1'b1; gnt = 1'b0;
    push(8'h5A, 8'h3C, 2'd2);
    tick(); tick();
    checks++; if (done !== 1'b0 || req !== 1'b1 || start !== 1'b0) begin errors++; $display("FAIL stray_req_ready: done=%b req=%b start=%b expected 0/1/0", done, req, start); end
    gnt = 1'b1;
    tick();
    checks++; if (start !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL stray_start: start=%b done=%b expected 1/0", start, done); end
    gnt = 1'b0;
    tick();
    checks++; if (done !== 1'b0 || start !== 1'b0) begin errors++; $display("FAIL stray_ready_in_start: done=%b start=%b expected 0/0", done, start); end
    ready = 1'b0; gnt = 1'b1;
    tick();
    gnt = 1'b0;
    checks++; if (start !== 1'b0 || done !== 1'b0 || req !== 1'b1) begin errors++; $display("FAIL stray_gnt_wait: start=%b done=%b req=%b expected 0/0/1", start, done, req); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++; if (done !== 1'b1 || req !== 1'b0) begin errors++; $display("FAIL stray_done: done=%b req=%b expected 1/0", done, req); end
    tick();
    checks++; if (done_cnt - d0 != 1 || start_cnt - s0 != 1) begin errors++; $display("FAIL stray_counts: done=%0d start=%0d expected 1/1", done_cnt - d0, start_cnt - s0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    gnt = 1'b0;
    push(8'h60, 8'h11, 2'd1);
    push(8'h61, 8'h22, 2'd2);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    tick(); // now in WAIT
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    checks++; if ({req, start, done, err, busy} !== 5'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ctrl: req/start/done/err/busy=%b cmd_ready=%b expected 00000/1", {req, start, done, err, busy}, cmd_ready); end
    checks++; if ({addr, data, mode} !== 18'h0) begin errors++; $display("FAIL rst_mid_bus: got %h expected 0", {addr, data, mode}); end
    ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1; ready = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0 || req !== 1'b0 || done_cnt != d0) begin errors++; $display("FAIL rst_mid_after: busy=%b req=%b dones=%0d expected 0/0/0", busy, req, done_cnt - d0); end
    push(8'h62, 8'h33, 2'd3);
    serve(1, 50);
    tick();
    checks++; if (done_cnt - d0 != 1 || done_log[$] !== {8'h62, 8'h33, 2'd3}) begin errors++; $display("FAIL rst_mid_new: dones=%0d last=%h expected 1/%h", done_cnt - d0, done_log[$], {8'h62, 8'h33, 2'd3}); end
  endtask

`ifdef SIMPLE_BUS_REQ_TIMEOUT_EN
  task automatic test_timeout();
    int d0 = done_cnt;
    int e0 = err_cnt;
    int k = 0;
    gnt = 1'b0;
    push(8'h70, 8'h01, 2'd0);
    push(8'h71, 8'h02, 2'd1);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL to_req_rise: req=%b expected 1", req); end
    while (err !== 1'b1 && k < 40) begin tick(); k++; end
    checks++; if (k != 16) begin errors++; $display("FAIL to_latency: err after %0d cycles expected 16", k); end
    checks++; if (req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL to_abort: req=%b done=%b expected 0/0", req, done); end
    tick();
    checks++; if (req !== 1'b1 || addr !== 8'h71 || err !== 1'b0) begin errors++; $display("FAIL to_next: req=%b addr=%h err=%b expected 1/71/0", req, addr, err); end
    serve(1, 50);
    tick();
    checks++; if (done_cnt - d0 != 1 || err_cnt - e0 != 1 || done_log[$] !== {8'h71, 8'h02, 2'd1}) begin errors++; $display("FAIL to_counts: dones=%0d errs=%0d last=%h expected 1/1/%h", done_cnt - d0, err_cnt - e0, done_log[$], {8'h71, 8'h02, 2'd1}); end
  endtask
`else
  task automatic test_no_timeout();
    int d0 = done_cnt;
    int e0 = err_cnt;
    gnt = 1'b0;
    push(8'h80, 8'h99, 2'd2);
    for (int i = 0; i < 40; i++) tick();
    checks++; if (req !== 1'b1 || start !== 1'b0 || err_cnt != e0) begin errors++; $display("FAIL nto_wait: req=%b start=%b errs=%0d expected 1/0/0", req, start, err_cnt - e0); end
    serve(1, 50);
    tick();
    checks++; if (done_cnt - d0 != 1 || done_log[$] !== {8'h80, 8'h99, 2'd2}) begin errors++; $display("FAIL nto_done: dones=%0d last=%h expected 1/%h", done_cnt - d0, done_log[$], {8'h80, 8'h99, 2'd2}); end
  endtask
`endif

  initial begin
    test_reset();
    test_simple();
    test_backpressure();
    test_push_pop();
    test_stray();
    test_reset_mid();
`ifdef SIMPLE_BUS_REQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
